slot_chain: RTL and testbench
=============================

SLOT_CHAIN -- requirements
Module: slot_chain

Interface
REQ-001 Parameter N_SLOTS, default 9, is the number of sequenced slots and SHALL be legal from 2 to 16.
REQ-002 Parameter N_IN, default 3, is the number of condition inputs per slot and SHALL be legal from 1 to 4.
REQ-003 Parameter HOLD, default 0, is the number of dwell cycles between a slot firing and the token advancing, and SHALL be legal from 0 to 255.
REQ-004 Parameter LOOP, default 0, SHALL select the end-of-chain action: 0 = one-shot, 1 = wrap to slot 0.
REQ-005 CLK  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-006 RESET  input  1  is the reset, asynchronous and active-low.
REQ-007 START  input  1  launches the token at slot 0.
REQ-008 CLEAR  input  1  is a synchronous abort that clears all latched outputs.
REQ-009 IN  input  N_SLOTS*N_IN  carries the condition inputs; slot k SHALL use bits [k*N_IN +: N_IN].
REQ-010 Q  output  N_SLOTS  carries the latched slot outputs, one bit per slot.
REQ-011 TOKEN  output  N_SLOTS  is the one-hot current slot, all-zero when no slot is armed.
REQ-012 BUSY  output  1  is high in states ARMED and DWELL.
REQ-013 DONE  output  1  is a one-cycle pulse on completion of the last slot.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, ARMED and DWELL; ptr SHALL be clog2(N_SLOTS) bits wide and the dwell counter clog2(HOLD+1) bits wide.
REQ-015 In IDLE, START=1 sampled on an edge SHALL move the FSM to ARMED with ptr=0, so that TOKEN[0]=1 after that edge.
REQ-016 A slot fires in ARMED when the AND of its N_IN bits is 1 at an edge; Q[ptr] SHALL be 1 after that same edge (latency 1 edge), and a set bit SHALL stay set until CLEAR or RESET.
REQ-017 On a firing with HOLD=0 and ptr<N_SLOTS-1, ptr SHALL increment at the same edge and the FSM SHALL remain in ARMED.
REQ-018 On a firing with HOLD>0 and ptr<N_SLOTS-1, the FSM SHALL enter DWELL, TOKEN SHALL hold, and after exactly HOLD further edges ptr SHALL increment and the FSM SHALL return to ARMED.
REQ-019 In DWELL, IN SHALL be ignored.
REQ-020 A firing with ptr=N_SLOTS-1 SHALL skip DWELL and SHALL assert DONE for the one cycle following that edge.
REQ-021 On that last-slot firing with LOOP=0, the FSM SHALL go to IDLE and TOKEN SHALL go to zero.
REQ-022 On that last-slot firing with LOOP=1, ptr SHALL go to 0, the FSM SHALL stay in ARMED, and Q SHALL be retained; re-firing an already-set slot SHALL keep its bit at 1.
REQ-023 START SHALL be ignored outside IDLE.
REQ-024 CLEAR=1 SHALL, at the next edge and from any state, set Q=0, ptr=0, FSM=IDLE and DONE=0.
REQ-025 CLEAR SHALL take priority over START and over a simultaneous firing.
REQ-026 TOKEN SHALL never have more than one bit set.
REQ-027 Only the slot at ptr SHALL fire; conditions on any other slot SHALL have no effect.

Reset
REQ-028 RESET=0 SHALL immediately, without waiting for a clock edge, force FSM=IDLE, ptr=0, dwell counter=0, Q=0, TOKEN=0, BUSY=0 and DONE=0.
REQ-029 RESET applied mid-DWELL SHALL cancel the pending advance, and after release the block SHALL require START to run again.
REQ-030 Release of RESET SHALL take effect at the first clock edge after deassertion, with no spurious firing.

Verification
REQ-031 Defaults, START, then IN slot k = 3'b111 applied one slot per cycle -> Q fills 0x001, 0x003 ... up to 0x1FF; DONE pulses once in the cycle Q=0x1FF; TOKEN=0 afterwards.
REQ-032 HOLD=2, slot 0 fires at edge t -> Q[0]=1 after t; TOKEN[1]=1 only after edge t+2; slot-0 conditions pulsed during t+1..t+2 cause no change.
REQ-033 Slot 3 inputs held at 3'b111 while ptr=1, partial pattern 3'b110 on slot 1 -> Q stays 0x001 and TOKEN stays 0x002.
REQ-034 LOOP=1, run the full chain then fire slot 0 again -> DONE pulse, TOKEN=0x001, Q stays 0x1FF, BUSY stays 1.
REQ-035 CLEAR and START in the same cycle while ptr=4 -> Q=0, TOKEN=0 and BUSY=0 after that edge; START ignored.
REQ-036 RESET low for half a clock period in DWELL -> all outputs 0 immediately; subsequent firing conditions with no START -> Q stays 0.

Source files
------------

// File: rtl/slot_chain_if.sv
// Bundle of control, condition and status signals for the slot_chain sequencer.
// No valid/ready pairs: start and clear are level requests sampled on each rising clk edge.
interface slot_chain_if #(
    parameter int N_SLOTS = 9,
    parameter int N_IN    = 3
);
    logic                      start;
    logic                      clear;
    logic [N_SLOTS*N_IN-1:0]   in;
    logic [N_SLOTS-1:0]        q;
    logic [N_SLOTS-1:0]        token;
    logic                      busy;
    logic                      done;
    logic [1:0]                state_dbg;

    modport master (
        output start, clear, in,
        input  q, token, busy, done, state_dbg
    );

    modport slave (
        input  start, clear, in,
        output q, token, busy, done, state_dbg
    );
endinterface

// File: rtl/slot_chain.sv
// Token-passing slot sequencer: each armed slot fires when all its conditions are high,
// latching its output bit and advancing the token, optionally after a dwell period.
module slot_chain #(
    parameter int N_SLOTS = 9,
    parameter int N_IN    = 3,
    parameter int HOLD    = 0,
    parameter int LOOP    = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    slot_chain_if.slave bus
);
    localparam int PTR_W = $clog2(N_SLOTS);
    localparam int CNT_W = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(N_SLOTS - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'((HOLD > 0) ? HOLD - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DWELL = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [PTR_W-1:0]   ptr, ptr_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [N_SLOTS-1:0] q, q_nx;
    logic               done, done_nx;

    logic [(1<<PTR_W)-1:0] cond;
    logic [N_SLOTS-1:0]    sel;
    logic                  fire;

    // cond is padded to a power of two so indexing by ptr never leaves the vector.
    always_comb begin
        cond = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            cond[k] = &bus.in[k*N_IN +: N_IN];
        end
    end

    assign sel  = N_SLOTS'(1) << ptr;
    assign fire = (state == ARMED) && cond[ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
            q     <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            cnt   <= cnt_nx;
            q     <= q_nx;
            done  <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        cnt_nx   = cnt;
        q_nx     = q;
        done_nx  = 1'b0;
        if (bus.clear) begin
            state_nx = IDLE;
            ptr_nx   = '0;
            cnt_nx   = '0;
            q_nx     = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state_nx = ARMED;
                        ptr_nx   = '0;
                        cnt_nx   = '0;
                    end
                end
                ARMED: begin
                    if (fire) begin
                        q_nx = q | sel;
                        if (ptr == LAST_PTR) begin
                            // Last slot never dwells; it completes on the firing edge.
                            done_nx  = 1'b1;
                            ptr_nx   = '0;
                            state_nx = (LOOP != 0) ? ARMED : IDLE;
                        end else if (HOLD == 0) begin
                            ptr_nx = ptr + 1'b1;
                        end else begin
                            state_nx = DWELL;
                            cnt_nx   = HOLD_LOAD;
                        end
                    end
                end
                DWELL: begin
                    // Loaded with HOLD-1 so the advance lands exactly HOLD edges after firing.
                    if (cnt == '0) begin
                        state_nx = ARMED;
                        ptr_nx   = ptr + 1'b1;
                    end else begin
                        cnt_nx = cnt - 1'b1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    ptr_nx   = '0;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    always_comb begin
        bus.q         = q;
        bus.done      = done;
        bus.busy      = (state != IDLE);
        bus.token     = (state != IDLE) ? sel : '0;
        bus.state_dbg = state;
    end
endmodule

// File: tb/tb_slot_chain.sv
// Directed bench for slot_chain: three instances cover the default, dwell and looping builds.
module tb_slot_chain;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    slot_chain_if #(.N_SLOTS(9), .N_IN(3)) if0 ();
    slot_chain_if #(.N_SLOTS(9), .N_IN(3)) if_h ();
    slot_chain_if #(.N_SLOTS(9), .N_IN(3)) if_l ();

    slot_chain #(.N_SLOTS(9), .N_IN(3), .HOLD(0), .LOOP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave));
    slot_chain #(.N_SLOTS(9), .N_IN(3), .HOLD(2), .LOOP(0)) dut_h (
        .clk(clk), .rst_n(rst_n), .bus(if_h.slave));
    slot_chain #(.N_SLOTS(9), .N_IN(3), .HOLD(0), .LOOP(1)) dut_l (
        .clk(clk), .rst_n(rst_n), .bus(if_l.slave));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [26:0] slot_bits(input int k, input logic [2:0] v);
        logic [26:0] r;
        r = 27'(v) << (3 * k);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if0.start = 0; if0.clear = 0; if0.in = '0;
        if_h.start = 0; if_h.clear = 0; if_h.in = '0;
        if_l.start = 0; if_l.clear = 0; if_l.in = '0;
        tick(); tick();
        n_tests++; if (if0.q !== 9'h000) begin n_fail++; $display("FAIL reset_q got=%h exp=000", if0.q); end
        n_tests++; if (if0.token !== 9'h000) begin n_fail++; $display("FAIL reset_token got=%h exp=000", if0.token); end
        n_tests++; if (if0.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", if0.busy); end
        n_tests++; if (if0.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", if0.done); end
        n_tests++; if (if0.state_dbg !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", if0.state_dbg); end
        rst_n = 1'b1;
        tick();
        n_tests++; if (if0.busy !== 1'b0) begin n_fail++; $display("FAIL post_release_busy got=%b exp=0", if0.busy); end
    endtask

    task automatic test_full_chain();
        logic [8:0] exp_q;
        logic [8:0] exp_tok;
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        n_tests++; if (if0.token !== 9'h001) begin n_fail++; $display("FAIL chain_start_token got=%h exp=001", if0.token); end
        n_tests++; if (if0.busy !== 1'b1) begin n_fail++; $display("FAIL chain_start_busy got=%b exp=1", if0.busy); end
        for (int k = 0; k < 9; k++) begin
            if0.in = slot_bits(k, 3'b111);
            tick();
            exp_q   = 9'((10'd1 << (k + 1)) - 10'd1);
            exp_tok = (k < 8) ? 9'(10'd1 << (k + 1)) : 9'h000;
            n_tests++; if (if0.q !== exp_q) begin n_fail++; $display("FAIL chain_q k=%0d got=%h exp=%h", k, if0.q, exp_q); end
            n_tests++; if (if0.token !== exp_tok) begin n_fail++; $display("FAIL chain_token k=%0d got=%h exp=%h", k, if0.token, exp_tok); end
            n_tests++; if (if0.done !== (k == 8)) begin n_fail++; $display("FAIL chain_done k=%0d got=%b exp=%b", k, if0.done, (k == 8)); end
        end
        if0.in = '0;
        tick();
        n_tests++; if (if0.done !== 1'b0) begin n_fail++; $display("FAIL chain_done_pulse got=%b exp=0", if0.done); end
        n_tests++; if (if0.token !== 9'h000) begin n_fail++; $display("FAIL chain_end_token got=%h exp=000", if0.token); end
        n_tests++; if (if0.busy !== 1'b0) begin n_fail++; $display("FAIL chain_end_busy got=%b exp=0", if0.busy); end
        n_tests++; if (if0.q !== 9'h1FF) begin n_fail++; $display("FAIL chain_end_q got=%h exp=1ff", if0.q); end
    endtask

    task automatic test_partial();
        if0.clear = 1'b1;
        tick();
        if0.clear = 1'b0;
        n_tests++; if (if0.q !== 9'h000) begin n_fail++; $display("FAIL clear_idle_q got=%h exp=000", if0.q); end
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        if0.in = slot_bits(0, 3'b111);
        tick();
        if0.in = slot_bits(3, 3'b111) | slot_bits(1, 3'b110);
        tick(); tick();
        n_tests++; if (if0.q !== 9'h001) begin n_fail++; $display("FAIL partial_q got=%h exp=001", if0.q); end
        n_tests++; if (if0.token !== 9'h002) begin n_fail++; $display("FAIL partial_token got=%h exp=002", if0.token); end
        if0.in = '0;
        if0.clear = 1'b1;
        tick();
        if0.clear = 1'b0;
    endtask

    task automatic test_clear_start();
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if0.in = slot_bits(k, 3'b111);
            tick();
        end
        n_tests++; if (if0.token !== 9'h010) begin n_fail++; $display("FAIL cs_pre_token got=%h exp=010", if0.token); end
        if0.in = slot_bits(4, 3'b111);
        if0.clear = 1'b1;
        if0.start = 1'b1;
        tick();
        if0.clear = 1'b0;
        if0.start = 1'b0;
        if0.in = '0;
        n_tests++; if (if0.q !== 9'h000) begin n_fail++; $display("FAIL cs_q got=%h exp=000", if0.q); end
        n_tests++; if (if0.token !== 9'h000) begin n_fail++; $display("FAIL cs_token got=%h exp=000", if0.token); end
        n_tests++; if (if0.busy !== 1'b0) begin n_fail++; $display("FAIL cs_busy got=%b exp=0", if0.busy); end
        n_tests++; if (if0.done !== 1'b0) begin n_fail++; $display("FAIL cs_done got=%b exp=0", if0.done); end
        tick();
        n_tests++; if (if0.busy !== 1'b0) begin n_fail++; $display("FAIL cs_after_busy got=%b exp=0", if0.busy); end
    endtask

    task automatic test_hold();
        if_h.start = 1'b1;
        tick();
        if_h.start = 1'b0;
        if_h.in = slot_bits(0, 3'b111);
        tick();
        n_tests++; if (if_h.q !== 9'h001) begin n_fail++; $display("FAIL hold_t_q got=%h exp=001", if_h.q); end
        n_tests++; if (if_h.token !== 9'h001) begin n_fail++; $display("FAIL hold_t_token got=%h exp=001", if_h.token); end
        n_tests++; if (if_h.state_dbg !== 2'd2) begin n_fail++; $display("FAIL hold_t_state got=%0d exp=2", if_h.state_dbg); end
        if_h.in = slot_bits(0, 3'b111) | slot_bits(1, 3'b111);
        tick();
        n_tests++; if (if_h.token !== 9'h001) begin n_fail++; $display("FAIL hold_t1_token got=%h exp=001", if_h.token); end
        n_tests++; if (if_h.q !== 9'h001) begin n_fail++; $display("FAIL hold_t1_q got=%h exp=001", if_h.q); end
        tick();
        if_h.in = '0;
        n_tests++; if (if_h.token !== 9'h002) begin n_fail++; $display("FAIL hold_t2_token got=%h exp=002", if_h.token); end
        n_tests++; if (if_h.q !== 9'h001) begin n_fail++; $display("FAIL hold_t2_q got=%h exp=001", if_h.q); end
        n_tests++; if (if_h.state_dbg !== 2'd1) begin n_fail++; $display("FAIL hold_t2_state got=%0d exp=1", if_h.state_dbg); end
        tick();
        n_tests++; if (if_h.q !== 9'h001) begin n_fail++; $display("FAIL hold_idle_q got=%h exp=001", if_h.q); end
    endtask

    task automatic test_reset_dwell();
        if_h.in = slot_bits(1, 3'b111);
        tick();
        if_h.in = '0;
        n_tests++; if (if_h.state_dbg !== 2'd2) begin n_fail++; $display("FAIL rd_pre_state got=%0d exp=2", if_h.state_dbg); end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (if_h.q !== 9'h000) begin n_fail++; $display("FAIL rd_q got=%h exp=000", if_h.q); end
        n_tests++; if (if_h.token !== 9'h000) begin n_fail++; $display("FAIL rd_token got=%h exp=000", if_h.token); end
        n_tests++; if (if_h.busy !== 1'b0) begin n_fail++; $display("FAIL rd_busy got=%b exp=0", if_h.busy); end
        n_tests++; if (if_h.done !== 1'b0) begin n_fail++; $display("FAIL rd_done got=%b exp=0", if_h.done); end
        #4;
        rst_n = 1'b1;
        if_h.in = slot_bits(0, 3'b111) | slot_bits(1, 3'b111) | slot_bits(2, 3'b111);
        tick(); tick(); tick(); tick();
        if_h.in = '0;
        n_tests++; if (if_h.q !== 9'h000) begin n_fail++; $display("FAIL rd_after_q got=%h exp=000", if_h.q); end
        n_tests++; if (if_h.token !== 9'h000) begin n_fail++; $display("FAIL rd_after_token got=%h exp=000", if_h.token); end
        n_tests++; if (if_h.busy !== 1'b0) begin n_fail++; $display("FAIL rd_after_busy got=%b exp=0", if_h.busy); end
    endtask

    task automatic test_loop();
        if_l.start = 1'b1;
        tick();
        if_l.start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if_l.in = slot_bits(k, 3'b111);
            tick();
        end
        n_tests++; if (if_l.done !== 1'b1) begin n_fail++; $display("FAIL loop_done got=%b exp=1", if_l.done); end
        n_tests++; if (if_l.token !== 9'h001) begin n_fail++; $display("FAIL loop_token got=%h exp=001", if_l.token); end
        n_tests++; if (if_l.q !== 9'h1FF) begin n_fail++; $display("FAIL loop_q got=%h exp=1ff", if_l.q); end
        n_tests++; if (if_l.busy !== 1'b1) begin n_fail++; $display("FAIL loop_busy got=%b exp=1", if_l.busy); end
        if_l.in = slot_bits(0, 3'b111);
        tick();
        if_l.in = '0;
        n_tests++; if (if_l.q !== 9'h1FF) begin n_fail++; $display("FAIL loop_refire_q got=%h exp=1ff", if_l.q); end
        n_tests++; if (if_l.token !== 9'h002) begin n_fail++; $display("FAIL loop_refire_token got=%h exp=002", if_l.token); end
        n_tests++; if (if_l.done !== 1'b0) begin n_fail++; $display("FAIL loop_refire_done got=%b exp=0", if_l.done); end
        n_tests++; if (if_l.busy !== 1'b1) begin n_fail++; $display("FAIL loop_refire_busy got=%b exp=1", if_l.busy); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_full_chain();
        test_partial();
        test_clear_start();
        test_hold();
        test_reset_dwell();
        test_loop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
